seg7_mux_driver: RTL

//  Downstream consumer of num_separator: latches the tens/units digit pair on an update strobe.

---
 rtl/seg7_mux_driver_pkg.sv | 33 +++
 rtl/seg7_decoder.sv | 27 ++
 rtl/seg7_mux_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seg7_mux_driver_pkg.sv
// Shared definitions for the two-digit 7-segment scan driver:
// FSM states, segment patterns {g,f,e,d,c,b,a} (bit 0 = a), digit enables.
package seg7_mux_driver_pkg;

  typedef enum logic [1:0] {
    UNI    = 2'd0,
    GAP_UD = 2'd1,
    DEC    = 2'd2,
    GAP_DU = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [1:0] DIG_OFF = 2'b00;
  localparam logic [1:0] DIG_UNI = 2'b01;
  localparam logic [1:0] DIG_DEC = 2'b10;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit -> segment pattern; anything above 9 shows "E".
// Ports: digit (8b binary in), seg (7b {g..a} active-high out).
module seg7_decoder
  import seg7_mux_driver_pkg::*;
(
  input  logic [7:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    unique case (digit)
      8'd0:    seg = SEG_0;
      8'd1:    seg = SEG_1;
      8'd2:    seg = SEG_2;
      8'd3:    seg = SEG_3;
      8'd4:    seg = SEG_4;
      8'd5:    seg = SEG_5;
      8'd6:    seg = SEG_6;
      8'd7:    seg = SEG_7;
      8'd8:    seg = SEG_8;
      8'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed common-cathode 7-seg driver with capture strobe.
// Ports: clk, rst_n, unidades/decenas/update/blank_lz in; seg, dig_en, err out.
module seg7_mux_driver
  import seg7_mux_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50,
  parameter int DEAD_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] unidades,
  input  logic [7:0] decenas,
  input  logic       update,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       err
);

  localparam int CW = $clog2(max2(REFRESH_DIV, DEAD_CYC) + 1);

  localparam logic [CW-1:0] REF_N  = CW'(REFRESH_DIV);
  localparam logic [CW-1:0] DEAD_N = CW'(DEAD_CYC);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic          upd_q, upd_d;
  logic [7:0]    uni_q, uni_d;
  logic [7:0]    dec_q, dec_d;
  logic          err_q, err_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          capture;
  logic          blank;
  logic [7:0]    dec_in;
  logic [6:0]    pat;

  assign capture = update & ~upd_q;

  always_comb begin
    upd_d = update;
    uni_d = uni_q;
    dec_d = dec_q;
    err_d = err_q;
    if (capture) begin
      uni_d = unidades;
      dec_d = decenas;
      err_d = (unidades > 8'd9) || (decenas > 8'd9);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= 1'b0;
      uni_q <= '0;
      dec_q <= '0;
      err_q <= 1'b0;
    end else begin
      upd_q <= upd_d;
      uni_q <= uni_d;
      dec_q <= dec_d;
      err_q <= err_d;
    end
  end

  // Counter holds cycles spent in the slot; entry loads 1.
  // Reset leaves it at 0 so the first UNI slot still lasts
  // REFRESH_DIV output cycles after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    unique case (state_q)
      UNI: if (cnt_q >= REF_N) begin
        state_d = (DEAD_CYC == 0) ? DEC : GAP_UD;
        cnt_d   = ONE;
      end
      GAP_UD: if (cnt_q >= DEAD_N) begin
        state_d = DEC;
        cnt_d   = ONE;
      end
      DEC: if (cnt_q >= REF_N) begin
        state_d = (DEAD_CYC == 0) ? UNI : GAP_DU;
        cnt_d   = ONE;
      end
      GAP_DU: if (cnt_q >= DEAD_N) begin
        state_d = UNI;
        cnt_d   = ONE;
      end
      default: begin
        state_d = UNI;
        cnt_d   = '0;
      end
    endcase
  end

  // Decode reads only the latched digits, so a capture on this
  // edge shows up one output cycle later.
  assign dec_in = (state_d == DEC) ? dec_q : uni_q;
  assign blank  = blank_lz && (dec_q == 8'd0);

  seg7_decoder u_dec (
    .digit (dec_in),
    .seg   (pat)
  );

  always_comb begin
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    unique case (1'b1)
      (state_d == UNI): begin
        seg_d = pat;
        dig_d = DIG_UNI;
      end
      (state_d == DEC && !blank): begin
        seg_d = pat;
        dig_d = DIG_DEC;
      end
      default: begin
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_q;
  assign err    = err_q;

endmodule
